instr_sequencer: RTL and testbench
==================================

# instr_sequencer

- Parametrised instruction sequencer that replaces hand-timed instruction stimulus with a loadable program buffer.
- Holds up to DEPTH instruction words and issues them in order to the processor core over a valid/ready handshake.
- Detects the all-zero HALT encoding, counts issued instructions and flags program overrun.
- Sits between the program loader (bench or boot logic) and the core's instruction input.

## Interface
- INSTR_W, 32, instruction word width
- DEPTH, 16, program buffer entries (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), buffer address width
- CNT_W, 16, issued-instruction counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  program write strobe
- wr_addr  in  ADDR_W  program write address
- wr_data  in  INSTR_W  program write data
- start  in  1  begin issuing from address 0 (single-cycle pulse)
- instr  out  INSTR_W  instruction presented to the core
- instr_valid  out  1  instr is valid
- instr_ready  in  1  core accepts instr this cycle
- pc  out  ADDR_W  buffer address of the presented word
- issued  out  CNT_W  instructions accepted since the last start (saturating)
- busy  out  1  FSM in RUN
- done  out  1  HALT accepted; program completed
- overrun  out  1  last entry accepted without HALT

## Operation
- FSM states: IDLE, RUN, HALTED, ERROR.
- IDLE: wr_en writes mem[wr_addr] <= wr_data. start -> RUN with pc=0, issued=0.
- RUN: instr = mem[pc] (combinational read); instr_valid=1.
  - On instr_valid && instr_ready:
    - issued increments, holding at all-ones.
    - instr == 0 (HALT): go to HALTED, done=1. HALT is issued and counted.
    - Else if pc == DEPTH-1: go to ERROR, overrun=1 (wrap behaviour under Configuration).
    - Else pc <= pc+1.
  - No acceptance: instr, pc and state hold.
- HALTED / ERROR: instr_valid=0; wr_en accepted; start restarts exactly as from IDLE and clears done/overrun.
- wr_en during RUN is ignored; the buffer is unchanged.
- start during RUN is ignored.
- Buffer contents are not reset; only control state resets.

## Timing
- Reset values: state=IDLE, pc=0, issued=0, instr_valid=0, busy=0, done=0, overrun=0. instr reflects mem[0] (don't-care while instr_valid=0).
- start at edge N -> instr_valid=1 and mem[0] on instr from cycle N+1.
- Zero-bubble issue: with instr_ready held high, one word per cycle.
- wr_en and start in the same IDLE cycle:
  - The write commits.
  - The first issued word reflects that write if wr_addr=0.
- A write in cycle N is visible to a start in cycle N+1.
- done/overrun assert the cycle after the accepting edge. They stay high until start or rst.
- Reset asserted mid-RUN: outputs take reset values immediately (asynchronous); there is no partial issue.

## Configuration
- INSTR_SEQ_WRAP_EN defined:
  - Acceptance of a non-HALT word at pc=DEPTH-1 wraps pc to 0 and stays in RUN.
  - ERROR is unreachable; overrun is tied 0.
- Not defined: the behaviour above (ERROR, overrun=1).

## Test plan
- Load the 8-word program: addi×4 (0x20080004, 0x2009000F, 0x200A0014, 0x20110008), sw×3 (0xAE280000, 0xAE290008, 0xAE2AFFFC), HALT 0x00000000. Pulse start with instr_ready=1.
  - Required: 8 consecutive words in order.
  - Required: done=1 one cycle after HALT, issued=8.
- Same program with instr_ready toggling 1,0,0,1…
  - Required: instr and pc stable through stalls.
  - Required: the word sequence is unchanged; issued=8.
- Fill all DEPTH=16 entries non-zero, start.
  - Without INSTR_SEQ_WRAP_EN: overrun=1 after 16 accepts, busy=0.
  - With INSTR_SEQ_WRAP_EN: pc returns to 0 and the 17th word equals mem[0].
- Pulse rst during the 4th word of a RUN.
  - Required: instr_valid=0, pc=0, issued=0 immediately.
  - Required: after reset release, a new start reissues from mem[0] with the buffer intact.
- In RUN, write 0x12345678 to address 5 before pc reaches 5.
  - Required: the originally loaded word is issued.
  - After HALTED, rewrite address 0 and start: the new word is issued first, done clears.
- With CNT_W=2, run a 6-word program plus HALT.
  - Required: issued saturates at 3.
  - Required: done asserts normally.

Source files
------------

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
//
// Loadable program buffer that issues instruction words, in address order, to
// a processor core over a valid/ready handshake. An all-zero word is the HALT
// encoding: it is issued and counted, and then the sequencer stops with done
// set. If the last buffer entry is accepted without a HALT, the sequencer
// stops with overrun set.
//
// Optional build macro:
//   INSTR_SEQ_WRAP_EN - a non-HALT word accepted at the last entry wraps pc to
//                       0 and issuing continues; overrun then stays 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset (control state only)
//   wr_en        in   program write strobe (ignored while busy)
//   wr_addr      in   program write address
//   wr_data      in   program write data
//   start        in   begin issuing from address 0 (ignored while busy)
//   instr        out  word presented to the core (mem[pc])
//   instr_valid  out  instr is valid
//   instr_ready  in   core accepts instr this cycle
//   pc           out  buffer address of the presented word
//   issued       out  words accepted since the last start, saturating
//   busy         out  sequencer is issuing
//   done         out  HALT accepted
//   overrun      out  last entry accepted without HALT
// ----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               start,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   issued,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

    state_e             state_q;
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic               valid_q, busy_q, done_q, overrun_q;
    logic               accept, is_halt, at_last;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Buffer is not reset; writes are locked out only while issuing.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q != S_RUN)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Combinational read so a word written in the start cycle is seen at once.
    assign instr    = mem_q[pc_q];
    assign accept   = valid_q && instr_ready;
    assign is_halt  = (instr == '0);
    assign at_last  = (pc_q == LAST_PC);
    assign issued_d = sat_inc(issued_q);
    assign pc_d     = at_last ? '0 : pc_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            issued_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (accept) begin
                        issued_q <= issued_d;
                        if (is_halt) begin
                            state_q <= S_HALTED;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (at_last) begin
`ifdef INSTR_SEQ_WRAP_EN
                            pc_q <= pc_d;
`else
                            state_q   <= S_ERROR;
                            valid_q   <= 1'b0;
                            busy_q    <= 1'b0;
                            overrun_q <= 1'b1;
`endif
                        end else begin
                            pc_q <= pc_d;
                        end
                    end
                end
                default: begin
                    // IDLE, HALTED and ERROR all restart identically.
                    if (start) begin
                        state_q   <= S_RUN;
                        pc_q      <= '0;
                        issued_q  <= '0;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        overrun_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign issued      = issued_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ----------------------------------------------------------------------------
// Scoreboard bench for instr_sequencer. At each start the reference model
// walks its own copy of the program buffer and queues the words the core
// should see; a monitor compares every presented word against the queue head
// and, one cycle after the final acceptance, the completion flags and counts.
// A second instance with CNT_W=2 runs in parallel to exercise saturation.
// ----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int INSTR_W = 32;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic               start;
    logic               instr_ready;

    logic [INSTR_W-1:0] instr, instr2;
    logic               instr_valid, valid2;
    logic [ADDR_W-1:0]  pc, pc2;
    logic [CNT_W-1:0]   issued;
    logic [1:0]         issued2;
    logic               busy, busy2, done, done2, overrun, overrun2;

    instr_sequencer #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .issued(issued), .busy(busy), .done(done), .overrun(overrun)
    );

    instr_sequencer #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .instr(instr2), .instr_valid(valid2), .instr_ready(instr_ready),
        .pc(pc2), .issued(issued2), .busy(busy2), .done(done2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [INSTR_W-1:0] w;
        logic [ADDR_W-1:0]  a;
    } exp_t;

    exp_t               exp_q[$];
    logic [INSTR_W-1:0] mmem [DEPTH];
    bit                 mrun;
    int                 end_kind;   // 0: none, 1: halt, 2: overrun
    int                 exp_cnt;
    bit                 pend;
    bit                 end_seen;
    int                 checks = 0;
    int                 errors = 0;
    int                 rmode  = 3;
    int                 cyc    = 0;

    logic [INSTR_W-1:0] prog [8] = '{32'h20080004, 32'h2009000F, 32'h200A0014, 32'h20110008,
                                     32'hAE280000, 32'hAE290008, 32'hAE2AFFFC, 32'h00000000};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: the sequence is mem[0], mem[1], ... up to and including the
    // first zero word; no zero anywhere means overrun (or one wrap back to 0).
    function automatic void build_expect();
        bit found = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found) begin
                exp_q.push_back('{mmem[i], ADDR_W'(i)});
                exp_cnt++;
                if (mmem[i] == '0) found = 1'b1;
            end
        end
        if (found) begin
            end_kind = 1;
        end else begin
`ifdef INSTR_SEQ_WRAP_EN
            exp_q.push_back('{mmem[0], ADDR_W'(0)});
            exp_cnt++;
            end_kind = 0;
`else
            end_kind = 2;
`endif
        end
        mrun = 1'b1;
    endfunction

    // Ready pattern generator.
    initial begin
        instr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       instr_ready = 1'b1;
                1:       instr_ready = (cyc % 3 == 0);
                2:       instr_ready = 1'($urandom_range(0, 1));
                default: instr_ready = 1'b0;
            endcase
            cyc++;
        end
    end

    // Monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pend) begin
                    pend = 1'b0;
                    chk("end_done", done, (end_kind == 1));
                    chk("end_overrun", overrun, (end_kind == 2));
                    chk("end_busy_valid", {busy, instr_valid}, 0);
                    chk("end_issued", issued, (exp_cnt > 65535) ? 65535 : exp_cnt);
                    chk("end_issued_sat", issued2, (exp_cnt > 3) ? 3 : exp_cnt);
                    chk("end_flags_cnt2", {done2, overrun2, busy2}, {(end_kind == 1), (end_kind == 2), 1'b0});
                    mrun     = 1'b0;
                    end_seen = 1'b1;
                end
                if (instr_valid) begin
                    if (exp_q.size() > 0) begin
                        chk("word", {pc, instr}, {exp_q[0].a, exp_q[0].w});
                        chk("word_cnt2", {valid2, pc2, instr2}, {1'b1, exp_q[0].a, exp_q[0].w});
                        if (instr_ready) begin
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0 && end_kind != 0) pend = 1'b1;
                        end
                    end else if (instr_ready) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue: pc=%0d instr=%h with no word expected", pc, instr);
                    end
                end
            end
        end
    end

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        if (!mrun) mmem[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_start(input bit with_wr, input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        if (with_wr) begin
            wr_en = 1'b1; wr_addr = a; wr_data = d;
            mmem[a] = d;
        end
        start    = 1'b1;
        end_seen = 1'b0;
        build_expect();
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        chk("after_start", {busy, instr_valid, done, overrun}, 4'b1100);
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (end_seen) break;
            @(posedge clk); #1;
        end
        if (!end_seen) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: %0d words still expected", exp_q.size());
            exp_q.delete();
            pend = 1'b0;
            mrun = 1'b0;
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 8; i++) write_word(ADDR_W'(i), prog[i]);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        mrun = 1'b0; pend = 1'b0; end_seen = 1'b0; end_kind = 0; exp_cnt = 0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'hFFFF_FFFF;
        #3;
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_issued", issued, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_ovr", {done, overrun}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reference program, ready held high.
        load_prog();
        rmode = 0;
        do_start(1'b0, '0, '0);
        wait_end(60);

        // Same program under 1,0,0 ready pattern.
        rmode = 1;
        cyc   = 0;
        do_start(1'b0, '0, '0);
        wait_end(100);

        // Writes while running are ignored; after HALT a rewrite of word 0 takes.
        rmode = 0;
        do_start(1'b0, '0, '0);
        write_word(4'd5, 32'h12345678);
        wait_end(60);
        write_word(4'd0, 32'h20420001);
        do_start(1'b0, '0, '0);
        wait_end(60);

        // Write and start in the same cycle.
        do_start(1'b1, 4'd0, 32'h11111111);
        wait_end(60);

        // Reset during the 4th word, then restart with the buffer intact.
        load_prog();
        do_start(1'b0, '0, '0);
        for (int i = 0; i < 40; i++) begin
            if (instr_valid && pc == 4'd3) break;
            @(posedge clk); #1;
        end
        chk("pre_rst_pc", {instr_valid, pc}, {1'b1, 4'd3});
        rst = 1'b1;
        #1;
        chk("mid_rst_valid_pc", {instr_valid, pc}, 0);
        chk("mid_rst_issued", {issued, issued2}, 0);
        exp_q.delete();
        pend = 1'b0;
        mrun = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_start(1'b0, '0, '0);
        wait_end(60);

        // Full buffer without HALT.
        for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), 32'hA000_0000 | 32'(i));
        do_start(1'b0, '0, '0);
`ifdef INSTR_SEQ_WRAP_EN
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("wrap_drained", exp_q.size(), 0);
        chk("wrap_busy_pc", {busy, overrun, pc}, {1'b1, 1'b0, 4'd1});
        rst = 1'b1;
        #1;
        exp_q.delete();
        mrun = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
`else
        wait_end(80);
`endif

        // Six words plus HALT: the 2-bit counter saturates at 3.
        for (int i = 0; i < 6; i++) write_word(ADDR_W'(i), 32'h3000_0000 + 32'(i));
        write_word(4'd6, 32'h0);
        do_start(1'b0, '0, '0);
        wait_end(60);

        // Randomised programs, ready and in-run writes.
        rmode = 2;
        for (int it = 0; it < 20; it++) begin
            int h;
            h = $urandom_range(0, DEPTH - 1);
            for (int i = 0; i < h; i++) write_word(ADDR_W'(i), $urandom | 32'h1);
            write_word(ADDR_W'(h), 32'h0);
            do_start(1'b0, '0, '0);
            if (h >= 2) write_word(ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom);
            wait_end(400);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
